// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo ranging receive path: detector state encoding
// and default timing constants, shared with the piezo controller.
package piezo_pkg;

  localparam int PIEZO_SYNC_STAGES    = 2;
  localparam int PIEZO_FILTER_LEN     = 8;
  localparam int PIEZO_BLANK_CYCLES   = 5000;
  localparam int PIEZO_TIMEOUT_CYCLES = 1000000;
  localparam int PIEZO_CNT_W          = 24;

  // The second-echo states only exist when the second-event build is selected.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_LISTEN  = 3'd2,
    ST_HOLD    = 3'd3
`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
    ,
    ST_BLANK2  = 3'd4,
    ST_LISTEN2 = 3'd5
`endif
  } piezo_det_state_t;

endpackage

// File: rtl/piezo_glitch_filter.sv
// Echo input conditioning: multi-flop synchroniser followed by counters of
// consecutive high samples (echo qualification) and consecutive low samples (quiet).
module piezo_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic echo_in,
  input  logic enable,
  output logic qualified,
  output logic quiet
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   echo_s;
  logic [FW-1:0]          filt_q;
  logic [FW-1:0]          filt_d;
  logic [FW-1:0]          quiet_q;
  logic [FW-1:0]          quiet_d;

  assign echo_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], echo_in};
    end
  end

  // Both counters saturate at FILTER_LEN so the flags stay asserted on long levels.
  always_comb begin
    filt_d  = '0;
    quiet_d = '0;
    if (enable && echo_s) begin
      filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + FW'(1);
    end
    if (!echo_s) begin
      quiet_d = (quiet_q == FILT_MAX) ? quiet_q : quiet_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q  <= '0;
      quiet_q <= '0;
    end else begin
      filt_q  <= filt_d;
      quiet_q <= quiet_d;
    end
  end

  assign qualified = (filt_q == FILT_MAX);
  assign quiet     = (quiet_q == FILT_MAX);

endmodule

// File: rtl/piezo_echo_detector.sv
// Piezo echo detector: arms on each transmit burst, blanks, qualifies an echo and
// reports the burst-to-echo cycle count. PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN adds a second echo.
module piezo_echo_detector
  import piezo_pkg::*;
#(
  parameter int SYNC_STAGES    = PIEZO_SYNC_STAGES,
  parameter int FILTER_LEN     = PIEZO_FILTER_LEN,
  parameter int BLANK_CYCLES   = PIEZO_BLANK_CYCLES,
  parameter int TIMEOUT_CYCLES = PIEZO_TIMEOUT_CYCLES,
  parameter int CNT_W          = PIEZO_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             piezo_enable,
  input  logic             echo_in,
  output logic             event_trigger,
  output logic             event_trigger2,
  output logic             timeout,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] elapsed,
  output logic             elapsed_valid
);

  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  piezo_det_state_t state_q, state_d;
  logic             en_q;
  logic             burst_start;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             trig_q, trig_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;
  logic             valid_q, valid_d;
  logic             filt_en;
  logic             qualified;
  logic             quiet;
`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
  logic             trig2_q, trig2_d;
`endif

  piezo_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .echo_in   (echo_in),
    .enable    (filt_en),
    .qualified (qualified),
    .quiet     (quiet)
  );

  assign burst_start = piezo_enable && !en_q;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    elapsed_d = elapsed_q;
    trig_d    = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    valid_d   = 1'b0;
    filt_en   = 1'b0;
`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
    trig2_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (burst_start) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          blank_d = '0;
        end
      end

      ST_BLANK: begin
        cnt_d   = cnt_inc;
        blank_d = blank_q + CNT_W'(1);
        if (blank_q == BLANK_LAST) begin
          state_d = ST_LISTEN;
        end
      end

      // Detection takes priority over a coincident timeout.
      ST_LISTEN: begin
        cnt_d   = cnt_inc;
        filt_en = 1'b1;
        if (qualified) begin
          trig_d    = 1'b1;
          valid_d   = 1'b1;
          elapsed_d = cnt_inc;
`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
          state_d   = ST_BLANK2;
          blank_d   = '0;
`else
          state_d   = ST_HOLD;
`endif
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
      // The timeout still runs from burst start while blanking for the second echo.
      ST_BLANK2: begin
        cnt_d   = cnt_inc;
        blank_d = blank_q + CNT_W'(1);
        if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (blank_q == BLANK_LAST) begin
          state_d = ST_LISTEN2;
        end
      end

      ST_LISTEN2: begin
        cnt_d   = cnt_inc;
        filt_en = 1'b1;
        if (qualified) begin
          trig2_d = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
`endif

      ST_HOLD: begin
        if (!piezo_enable && quiet) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (burst_start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      blank_q   <= '0;
      elapsed_q <= '0;
      trig_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= piezo_enable;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      elapsed_q <= elapsed_d;
      trig_q    <= trig_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != ST_IDLE);
      valid_q   <= valid_d;
    end
  end

`ifdef PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig2_q <= 1'b0;
    end else begin
      trig2_q <= trig2_d;
    end
  end

  assign event_trigger2 = trig2_q;
`else
  assign event_trigger2 = 1'b0;
`endif

  assign event_trigger = trig_q;
  assign timeout       = timeout_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;
  assign elapsed       = elapsed_q;
  assign elapsed_valid = valid_q;

endmodule

// File: doc/piezo_echo_detector.md
# piezo_echo_detector

Receive-side front end for the piezo ranging path. Watches the asynchronous comparator output of the piezo receiver and arms on each transmit burst (`piezo_enable` from the RTC). After a blanking window, it qualifies an echo with a glitch filter. It then emits the single-cycle `event_trigger` pulse consumed by `rtc_0` and reports the enable-to-echo cycle count.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `echo_in`, minimum 2.
- `FILTER_LEN`, 8: consecutive high samples required to qualify an echo, minimum 1.
- `BLANK_CYCLES`, 5000: cycles ignored after burst start.
- `TIMEOUT_CYCLES`, 1000000: listen abort limit. Must be greater than `BLANK_CYCLES` and less than 2^`CNT_W`.
- `CNT_W`, 24: elapsed counter width.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `piezo_enable` in 1: burst-active level from the RTC, synchronous to `clk`.
- `echo_in` in 1: raw receiver comparator output, asynchronous.
- `event_trigger` out 1: one-cycle pulse on the first qualified echo; feeds `rtc_0` `event_trigger`.
- `event_trigger2` out 1: one-cycle pulse on the second qualified echo; feeds `rtc_0` `event_trigger2`.
- `timeout` out 1: one-cycle pulse when no echo is qualified in time.
- `overrun` out 1: one-cycle pulse when a burst start arrives while the block is busy.
- `busy` out 1: high whenever the block is not in IDLE.
- `elapsed` out `CNT_W`: cycle count captured at the first detection.
- `elapsed_valid` out 1: one-cycle pulse, coincident with `event_trigger`.

## Operation
- `echo_in` passes through `SYNC_STAGES` flops. Only the synchronised value is used.
- A burst start is a rising edge of `piezo_enable`, detected against a registered copy of it.
- FSM states: IDLE, BLANK, LISTEN, BLANK2, LISTEN2, HOLD.
  - IDLE → BLANK on burst start. The elapsed counter is cleared to 0.
  - BLANK: counter increments every cycle. Leaves for LISTEN when counter equals `BLANK_CYCLES`-1. The filter is held at 0.
  - LISTEN: counter keeps incrementing.
    - Filter counter increments while the synced input is high and clears to 0 when it is low.
    - When the filter reaches `FILTER_LEN`: pulse `event_trigger` and `elapsed_valid`, latch `elapsed`, then go to BLANK2 (macro on) or HOLD (macro off).
    - When the counter equals `TIMEOUT_CYCLES`-1 without detection: pulse `timeout` and go to IDLE.
    - If detection and timeout occur in the same cycle, detection wins.
  - BLANK2 / LISTEN2: same as BLANK / LISTEN, with the blank counter restarted from 0.
    - Detection pulses `event_trigger2` and goes to HOLD.
    - Timeout is measured from burst start, pulses `timeout`, and goes to HOLD.
  - HOLD → IDLE once `piezo_enable` is low and the synced input has been low for `FILTER_LEN` consecutive cycles.
- A burst start in any state other than IDLE is ignored, pulses `overrun`, and does not disturb the current measurement.
- The elapsed counter saturates at all-ones and never wraps.
- Reset asserted mid-operation returns the block to IDLE immediately.
- Reset values: all outputs 0 (`elapsed` = 0, `busy` = 0); synchroniser, filter and counters 0; state IDLE.

## Timing
- All outputs are registered.
- `busy` rises one cycle after the `piezo_enable` rising edge is sampled.
- `event_trigger` is high exactly `SYNC_STAGES`+`FILTER_LEN` cycles after the first clock edge that samples `echo_in` high, given the block is already in LISTEN.
- `elapsed` equals the number of cycles from the burst-start cycle to the detection cycle. It holds its value until the next detection.
- A minimum-width echo is `FILTER_LEN` cycles of high level. Shorter pulses are rejected.

## Configuration
- Macro: `PIEZO_ECHO_DETECTOR_SECOND_EVENT_EN`.
- Defined: BLANK2 and LISTEN2 are compiled in and `event_trigger2` is live.
- Undefined: those states are absent, LISTEN detection goes directly to HOLD, and `event_trigger2` is tied to 0. The port list is unchanged.

## Structure
- Shared package `piezo_pkg` holds:
  - the state enum `piezo_det_state_t`;
  - default parameter constants, shared with the piezo controller;
  - the `CNT_W` default.
- Sub-module `piezo_glitch_filter` contains the synchroniser plus the consecutive-sample counter. It has `qualified` and `quiet` outputs and is instantiated once.
- The FSM and counters live in the top module.

## Test plan
All scenarios use parameters `BLANK_CYCLES`=16, `FILTER_LEN`=4, `TIMEOUT_CYCLES`=200, `SYNC_STAGES`=2.
- Echo held high from cycle 50 after burst start → one `event_trigger` pulse 6 cycles later; `elapsed` = 56 (±0); `busy` stays high until `piezo_enable` is low and the input has been quiet for 4 cycles.
- Echo high only during cycles 2–12 (inside BLANK) → no trigger.
- Three-cycle glitch in LISTEN, followed by a long echo → only the long echo triggers.
- No echo → `timeout` pulse at counter 199, then IDLE; `event_trigger` never fires.
- Second burst start at cycle 30 → `overrun` pulse; the first measurement completes unchanged.
- Macro on: echoes at cycles 50 and 100 → `event_trigger` and then `event_trigger2`. Macro off: `event_trigger2` stays 0.
- Reset asserted in LISTEN → all outputs 0 immediately; the next burst measures normally.
